// File: rtl/uart_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_receiver: 8N1 UART receiver, run-time bit-period divisor,       |
// | one-entry valid/ready output buffer with framing/overrun pulses.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_receiver #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             rxd,
  input  logic             rdy,
  output logic [7:0]       d,
  output logic             vld,
  output logic             ferr,
  output logic             ovr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             rxs_q, rxs_d;
  logic [DIV_W-1:0] t_q, t_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       d_q, d_d;
  logic             vld_q, vld_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic [DIV_W-1:0] half_m1;
  logic [DIV_W-1:0] last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      t_q     <= DIV_W'(4);
      cnt_q   <= '0;
      bcnt_q  <= 4'd0;
      sh_q    <= 8'h00;
      d_q     <= 8'h00;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      rxs_q   <= rxs_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      d_q     <= d_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sync1_d = rxd;
    rxs_d   = sync1_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    d_d     = d_q;
    vld_d   = vld_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    half_m1 = (t_q >> 1) - 1'b1;
    last    = t_q - 1'b1;

    // A handshake frees the buffer; a stop completing this cycle may refill it.
    if (vld_q && rdy) vld_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          t_d     = (div < DIV_W'(4)) ? DIV_W'(4) : div;
          cnt_d   = '0;
          bcnt_d  = 4'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == half_m1) begin
          cnt_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == last) begin
          sh_d   = {rxs_q, sh_q[7:1]};
          cnt_d  = '0;
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == 4'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == last) begin
          cnt_d = '0;
          if (rxs_q) begin
            if (vld_q && !rdy) begin
              ovr_d = 1'b1;
            end else begin
              d_d   = sh_q;
              vld_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign d    = d_q;
  assign vld  = vld_q;
  assign ferr = ferr_q;
  assign ovr  = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// Bench for uart_receiver: directed frames plus randomized bytes/divisors,
// checked against frame-level expectations (byte value, latency, pulse counts).
module tb_uart_receiver;
  localparam int DIV_W = 16;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             rxd   = 1'b1;
  logic             rdy   = 1'b1;
  logic [DIV_W-1:0] div   = DIV_W'(25);
  logic [7:0]       d;
  logic             vld, ferr, ovr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         vld_cycles = 0;
  int         ferr_cnt   = 0;
  int         ovr_cnt    = 0;
  logic       vld_prev   = 1'b0;
  logic       hs_prev    = 1'b0;

  uart_receiver #(.DIV_W(DIV_W)) dut (
    .clk  (clk),
    .reset(reset),
    .div  (div),
    .rxd  (rxd),
    .rdy  (rdy),
    .d    (d),
    .vld  (vld),
    .ferr (ferr),
    .ovr  (ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A new byte is presented when vld rises, or stays high right after a handshake.
  always @(negedge clk) begin
    if (vld && (!vld_prev || hs_prev)) begin
      got_q.push_back(d);
      got_cyc.push_back(cyc);
    end
    if (vld)  vld_cycles <= vld_cycles + 1;
    if (ferr) ferr_cnt   <= ferr_cnt + 1;
    if (ovr)  ovr_cnt    <= ovr_cnt + 1;
    vld_prev <= vld;
    hs_prev  <= vld & rdy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_t(input int dv);
    return (dv < 4) ? 4 : dv;
  endfunction

  // Pin fall to first cycle vld is seen: 2 sync stages, half a bit, 9 bits, 1 register.
  function automatic int lat(input int dv);
    return 3 + eff_t(dv) / 2 + 9 * eff_t(dv);
  endfunction

  task automatic send_frame(input logic [7:0] b, input int t, input logic stop_bit);
    rxd = 1'b0;
    tick(t);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(t);
    end
    rxd = stop_bit;
    tick(t);
  endtask

  task automatic expect_byte(input string tag, input int base, input logic [7:0] exp,
                             input int fall, input int dv);
    chk({tag, "_cnt"}, 32'(got_q.size()), 32'(base + 1));
    if (got_q.size() > base) begin
      chk({tag, "_d"}, 32'(got_q[base]), 32'(exp));
      chk({tag, "_lat"}, 32'(got_cyc[base] - fall), 32'(lat(dv)));
    end
  endtask

  initial begin
    int base, f0, f1, fcnt, ocnt, vc, dv;
    logic [7:0] b;

    #2 reset = 1'b0;
    #1;
    chk("rst_d", 32'(d), 32'h0);
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_ferr", 32'(ferr), 32'h0);
    chk("rst_ovr", 32'(ovr), 32'h0);
    tick(3);
    reset = 1'b1;
    tick(5);

    // Single byte, rdy high: one-cycle vld pulse at the predicted cycle.
    base = got_q.size(); vc = vld_cycles; fcnt = ferr_cnt; ocnt = ovr_cnt;
    f0 = cyc;
    send_frame(8'hA5, 25, 1'b1);
    tick(20);
    expect_byte("single", base, 8'hA5, f0, 25);
    chk("single_vldw", 32'(vld_cycles - vc), 32'd1);
    chk("single_ferr", 32'(ferr_cnt - fcnt), 32'd0);
    chk("single_ovr", 32'(ovr_cnt - ocnt), 32'd0);

    // Back-to-back under backpressure: first byte held, second dropped with ovr.
    rdy = 1'b0;
    base = got_q.size(); ocnt = ovr_cnt;
    send_frame(8'h3C, 25, 1'b1);
    send_frame(8'hC3, 25, 1'b1);
    tick(20);
    chk("bp_cnt", 32'(got_q.size()), 32'(base + 1));
    chk("bp_d", 32'(d), 32'h3C);
    chk("bp_vld", 32'(vld), 32'h1);
    chk("bp_ovr", 32'(ovr_cnt - ocnt), 32'd1);
    rdy = 1'b1;
    tick(3);
    chk("bp_drain_vld", 32'(vld), 32'h0);
    chk("bp_drain_cnt", 32'(got_q.size()), 32'(base + 1));

    // Framing error followed by a long break: exactly one ferr, no byte.
    base = got_q.size(); fcnt = ferr_cnt;
    send_frame(8'h55, 25, 1'b0);
    tick(40 * 25);
    chk("fe_ferr", 32'(ferr_cnt - fcnt), 32'd1);
    chk("fe_cnt", 32'(got_q.size()), 32'(base));
    chk("fe_vld", 32'(vld), 32'h0);
    rxd = 1'b1;
    tick(50);
    f0 = cyc;
    send_frame(8'h12, 25, 1'b1);
    tick(20);
    expect_byte("fe_recover", base, 8'h12, f0, 25);

    // Short glitch is rejected as a false start.
    base = got_q.size(); fcnt = ferr_cnt;
    rxd = 1'b0;
    tick(5);
    rxd = 1'b1;
    tick(60);
    chk("glitch_cnt", 32'(got_q.size()), 32'(base));
    chk("glitch_ferr", 32'(ferr_cnt - fcnt), 32'd0);
    f0 = cyc;
    send_frame(8'hFF, 25, 1'b1);
    tick(20);
    expect_byte("glitch_ff", base, 8'hFF, f0, 25);

    // Divisor below the minimum runs at T=4.
    div = DIV_W'(2);
    base = got_q.size();
    f0 = cyc;
    send_frame(8'h81, 4, 1'b1);
    tick(10);
    expect_byte("clamp", base, 8'h81, f0, 2);

    // Divisor change mid-frame is ignored until the next start bit.
    div = DIV_W'(25);
    base = got_q.size();
    f0 = cyc;
    fork
      send_frame(8'h6B, 25, 1'b1);
      begin tick(60); div = DIV_W'(100); end
    join
    tick(20);
    expect_byte("middiv", base, 8'h6B, f0, 25);
    div = DIV_W'(25);

    // Asynchronous reset during data bit 3 clears a held output immediately.
    rdy = 1'b0;
    base = got_q.size();
    f0 = cyc;
    send_frame(8'h99, 25, 1'b1);
    tick(20);
    expect_byte("pre_rst", base, 8'h99, f0, 25);
    chk("pre_rst_vld", 32'(vld), 32'h1);
    base = got_q.size();
    fork
      send_frame(8'hF0, 25, 1'b1);
      begin
        tick(110);
        reset = 1'b0;
        #1;
        chk("mrst_d", 32'(d), 32'h0);
        chk("mrst_vld", 32'(vld), 32'h0);
        chk("mrst_ferr", 32'(ferr), 32'h0);
        chk("mrst_ovr", 32'(ovr), 32'h0);
        tick(25);
        reset = 1'b1;
      end
    join
    tick(20);
    chk("mrst_nobyte", 32'(got_q.size()), 32'(base));
    rdy = 1'b1;
    f0 = cyc;
    send_frame(8'h7E, 25, 1'b1);
    tick(20);
    expect_byte("post_rst", base, 8'h7E, f0, 25);

    // Handshake in the same cycle as the stop sample: new byte loads, no ovr.
    rdy = 1'b0;
    send_frame(8'h5A, 25, 1'b1);
    tick(20);
    chk("hold_5a", 32'(d), 32'h5A);
    base = got_q.size(); ocnt = ovr_cnt;
    f1 = cyc;
    fork
      send_frame(8'h7E, 25, 1'b1);
      begin tick(lat(25) - 1); rdy = 1'b1; end
    join
    tick(20);
    chk("coin_ovr", 32'(ovr_cnt - ocnt), 32'd0);
    expect_byte("coin", base, 8'h7E, f1, 25);
    chk("coin_vld", 32'(vld), 32'h0);

    // Random bytes at random divisors (including clamped values).
    for (int i = 0; i < 6; i++) begin
      dv = int'($urandom_range(1, 30));
      b  = 8'($urandom);
      div = DIV_W'(dv);
      base = got_q.size(); fcnt = ferr_cnt; ocnt = ovr_cnt;
      f0 = cyc;
      send_frame(b, eff_t(dv), 1'b1);
      tick(10);
      expect_byte("rand", base, b, f0, dv);
      chk("rand_err", 32'((ferr_cnt - fcnt) + (ovr_cnt - ocnt)), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. It is the receive half paired with `uart_tx` inside the echo path. It recovers bytes from `rxd` using the same run-time bit-period divisor the transmitter uses. Received bytes are presented on a valid/ready output that drives `uart_tx`'s valid/ready input directly.

## Interface
- `DIV_W`, default 16: width of the bit-period divisor input.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `div`  in  DIV_W  bit period in `clk` cycles (T). Sampled only at start-bit detection. Values below 4 are treated as 4.
- `rxd`  in  1  serial input, asynchronous to `clk`.
- `rdy`  in  1  downstream ready.
- `d`  out  8  received byte; stable while `vld`=1.
- `vld`  out  1  byte available.
- `ferr`  out  1  one-cycle pulse: framing error (stop bit sampled 0).
- `ovr`  out  1  one-cycle pulse: byte completed while the output buffer was still full, so the byte was dropped.

## Operation
- **Input synchronizer:** 2-flop synchronizer on `rxd`, both flops reset to 1. All FSM decisions use the synchronized value `rxs`.
- **State machine:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:** when `rxs`=0, latch T = max(`div`,4), clear cycle counter `cnt` and bit counter `bcnt`, go to START.
- **START:** `cnt` counts up each cycle. When `cnt` = floor(T/2)-1, sample `rxs`:
  - 0: clear `cnt`, go to DATA.
  - 1: false start; go to IDLE with no output activity.
- **DATA:** `cnt` counts 0..T-1.
  - At `cnt`=T-1: shift `rxs` into the MSB of the shift register (so LSB first lands at bit 0), clear `cnt`, increment `bcnt`.
  - After the 8th sample, go to STOP.
- **STOP:** at `cnt`=T-1, sample `rxs`:
  - 1, buffer free: load `d` with the shift register, set `vld`=1, go to IDLE.
  - 1, buffer full (`vld`=1 and `rdy`=0 that cycle): keep `d` unchanged, pulse `ovr`, go to IDLE.
  - 0: pulse `ferr`, discard the byte, go to BREAK.
- **BREAK:** wait until `rxs`=1, then go to IDLE. A held-low line yields exactly one `ferr` and no further frames.
- **Output buffer:** one entry.
  - `vld` clears on the cycle after a `vld`&`rdy` handshake.
  - If a handshake and a successful stop sample occur in the same cycle, the new byte loads, `vld` stays 1, and no `ovr` is raised.
- **Mid-frame changes to `div`** have no effect until the next start bit.

## Timing
- **Reset values:** `d`=8'h00, `vld`=0, `ferr`=0, `ovr`=0; FSM in IDLE; synchronizer flops=1; `cnt`=0, `bcnt`=0.
- **Reset is asynchronous** and may assert mid-frame. The partial frame is abandoned. After release the block waits in IDLE for a new falling edge; a line that is still low then starts a new frame.
- **Reference cycle:** let c0 be the first cycle `rxs`=0 in IDLE. This is 2–3 cycles after the `rxd` pin falls.
- **Sample points** (relative to c0):
  - start bit: c0+floor(T/2)
  - data bit k (k=0..7): c0+floor(T/2)+(k+1)·T
  - stop bit: c0+floor(T/2)+9T
- **Outputs:** `vld`, `d`, `ferr` and `ovr` are registered and update on the cycle after the stop sample, i.e. c0+floor(T/2)+9T+1.
- **Example, T=25:** stop sample at c0+237; `vld` rises at c0+238.
- **Back-to-back frames:** the FSM returns to IDLE immediately after the stop sample. A start edge arriving half a bit later is therefore detected.
- **Counter widths:** `cnt` is DIV_W bits; `bcnt` is 4 bits. No wrap occurs because `cnt` resets at T-1.

## Test plan
- **Single byte:** `div`=25, `rdy`=1, send 8'hA5 at 25 cycles/bit → `vld` pulses for 1 cycle at c0+238 with `d`=8'hA5; `ferr`=`ovr`=0.
- **Back-to-back with backpressure:** `div`=25, `rdy`=0, send 8'h3C then 8'hC3 back-to-back → `d`=8'h3C held with `vld`=1; `ovr` pulses once at the second stop; raising `rdy` drops `vld`.
- **Framing error:** send 8'h55 with stop bit 0, then hold `rxd` low for 40 bit times → exactly one `ferr` pulse; `vld` stays 0. After `rxd` returns high, send 8'h12 → `d`=8'h12.
- **False start:** a 5-cycle low glitch on an idle line with `div`=25 → FSM returns to IDLE; no `vld`/`ferr`. A following 8'hFF frame is received correctly.
- **Minimum and clamped divisor:** `div`=2 → behaves as T=4; 8'h81 sent at 4 cycles/bit is received. Also change `div` mid-frame from 25 to 100 → the current byte is still sampled at T=25.
- **Reset mid-frame:** assert `reset`=0 during data bit 3 → all outputs 0 immediately. After release, a complete 8'h7E frame is received correctly, and handshake-coincident completion (`rdy`=1 at stop) produces no `ovr`.
